// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame sequencer state
// encoding, the divisor width used between the sequencer and its baud tick
// counter, and the idle level of the serial line.
package uart_pkg;

  // Width of the bit-period divisor handed to the tick counter.
  localparam int BAUD_DIV_W = 32;

  // Level the tx line rests at between frames (mark).
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Frame sequencer states. PARITY is only entered when the parity bit is
  // compiled in; the encoding stays the same either way.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

endpackage : uart_pkg

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer.
//
// Accepts a word on a valid/ready handshake, latches it together with the
// bit-period divisor, then frames it onto tx as START, DATA (LSB first),
// optional PARITY and STOP bits. Bit timing comes from an external tick
// counter: baud_start enables it for the whole frame, baud_divisor sets the
// period and baud_tick marks the last cycle of each bit.
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit between the
// data and stop bits (even parity, or odd when PARITY_ODD=1). Without it
// there is no parity state and no parity logic.
//
// tx_abort drops the frame at any point while busy and returns the line to
// idle on the next cycle. Every output comes straight from a flop.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [DATA_BITS-1:0]  tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [BAUD_DIV_W-1:0] divisor,
  input  logic                  tx_abort,
  output logic                  baud_start,
  output logic [BAUD_DIV_W-1:0] baud_divisor,
  input  logic                  baud_tick,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  // Bit counter only needs to reach DATA_BITS-1 (at most 8).
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_DATA_BIT = CNT_W'(DATA_BITS - 1);
  // Stop counter counts down from STOP_BITS-1 to 0 (one or two stop bits).
  localparam logic STOP_LOAD = 1'(STOP_BITS - 1);

  // Reject parameter values the framing logic was not built for.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_ctrl: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_ctrl: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_ctrl: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t          state_q, state_d;
  logic                    tx_q, tx_d;
  logic                    tx_ready_q, tx_ready_d;
  logic                    busy_q, busy_d;
  logic                    baud_start_q, baud_start_d;
  logic [BAUD_DIV_W-1:0]   baud_divisor_q, baud_divisor_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic [DATA_BITS-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
`ifdef UART_TX_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  logic tick;

  // A tick only counts while the counter is enabled, so a stray tick in
  // IDLE can never move the sequencer.
  assign tick = baud_tick & baud_start_q;

  // Next-state logic: accept in IDLE, otherwise abort or step on each tick.
  always_comb begin
    state_d        = state_q;
    tx_d           = tx_q;
    tx_ready_d     = tx_ready_q;
    busy_d         = busy_q;
    baud_start_d   = baud_start_q;
    baud_divisor_d = baud_divisor_q;
    done_d         = 1'b0;
    aborted_d      = 1'b0;
    shreg_d        = shreg_q;
    bit_cnt_d      = bit_cnt_q;
    stop_cnt_d     = stop_cnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d       = parity_q;
`endif

    if (state_q == IDLE) begin
      tx_d         = UART_IDLE_LEVEL;
      tx_ready_d   = 1'b1;
      busy_d       = 1'b0;
      baud_start_d = 1'b0;
      // tx_abort is deliberately not looked at here: an accept in the same
      // cycle wins, and an abort with nothing in flight means nothing.
      if (tx_valid && tx_ready_q) begin
        shreg_d        = tx_data;
        baud_divisor_d = divisor;
        bit_cnt_d      = '0;
        stop_cnt_d     = STOP_LOAD;
`ifdef UART_TX_PARITY_EN
        parity_d       = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        state_d        = START;
        tx_d           = 1'b0;
        busy_d         = 1'b1;
        tx_ready_d     = 1'b0;
        baud_start_d   = 1'b1;
      end
    end else if (tx_abort) begin
      // Abort beats a tick arriving in the same cycle.
      state_d      = IDLE;
      tx_d         = UART_IDLE_LEVEL;
      tx_ready_d   = 1'b1;
      busy_d       = 1'b0;
      baud_start_d = 1'b0;
      aborted_d    = 1'b1;
    end else if (tick) begin
      case (state_q)
        START: begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
        DATA: begin
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            stop_cnt_d = STOP_LOAD;
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
            tx_d       = parity_q;
`else
            state_d    = STOP;
            tx_d       = UART_IDLE_LEVEL;
`endif
          end else begin
            tx_d = shreg_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state_d = STOP;
          tx_d    = UART_IDLE_LEVEL;
        end
`endif
        STOP: begin
          if (stop_cnt_q == 1'b0) begin
            state_d      = IDLE;
            tx_d         = UART_IDLE_LEVEL;
            tx_ready_d   = 1'b1;
            busy_d       = 1'b0;
            baud_start_d = 1'b0;
            done_d       = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q - 1'b1;
          end
        end
        default: begin
          state_d      = IDLE;
          tx_d         = UART_IDLE_LEVEL;
          tx_ready_d   = 1'b1;
          busy_d       = 1'b0;
          baud_start_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset puts the line at idle immediately.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q        <= IDLE;
      tx_q           <= UART_IDLE_LEVEL;
      tx_ready_q     <= 1'b1;
      busy_q         <= 1'b0;
      baud_start_q   <= 1'b0;
      baud_divisor_q <= '0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      shreg_q        <= '0;
      bit_cnt_q      <= '0;
      stop_cnt_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      tx_q           <= tx_d;
      tx_ready_q     <= tx_ready_d;
      busy_q         <= busy_d;
      baud_start_q   <= baud_start_d;
      baud_divisor_q <= baud_divisor_d;
      done_q         <= done_d;
      aborted_q      <= aborted_d;
      shreg_q        <= shreg_d;
      bit_cnt_q      <= bit_cnt_d;
      stop_cnt_q     <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_ready     = tx_ready_q;
  assign busy         = busy_q;
  assign baud_start   = baud_start_q;
  assign baud_divisor = baud_divisor_q;
  assign done         = done_q;
  assign aborted      = aborted_q;

endmodule : uart_tx_ctrl
